// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared definitions for the traffic phase sequencer: phase encodings,
// light codes and small decode helpers.
package traffic_phase_sequencer_pkg;

  // Lights are {red,yellow,green}, one-hot.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_B    = 3'd5
  } phase_t;

  // Unlisted encodings decode to red so a corrupted state can never
  // show a conflicting green/yellow.
  function automatic logic [2:0] main_light_of(input phase_t p);
    case (p)
      MAIN_GREEN:  return LIGHT_GRN;
      MAIN_YELLOW: return LIGHT_YEL;
      default:     return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_light_of(input phase_t p);
    case (p)
      SIDE_GREEN:  return LIGHT_GRN;
      SIDE_YELLOW: return LIGHT_YEL;
      default:     return LIGHT_RED;
    endcase
  endfunction

  // True when a positive duration is representable in w bits.
  function automatic bit duration_ok(input int val, input int w);
    return (val >= 1) && ((val >> w) == 0);
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// phase_timer: loadable, saturating down-counter driven by the 1 Hz tick.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset (count <= RST_VAL)
//   load      - load load_val this clk (wins over tick)
//   load_val  - duration of the phase being entered
//   tick      - one-clk time-base enable
//   count     - ticks remaining, saturates at 0
//   last      - tick && count<=1: this tick expires the phase
module phase_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = tick && (count <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_W'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: two-road traffic-light controller timed by the
// divider's 1 Hz single-clk enable. Main road rests in green; a latched
// side-road request is served once main minimum-green has elapsed.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   oneHz_enable  - one-clk tick, the only time base
//   side_req      - side-road sensor, sampled every clk
//   main_light    - {red,yellow,green} registered
//   side_light    - {red,yellow,green} registered
//   req_pending   - latched side request awaiting service
//   seconds_left  - ticks remaining in current phase (0 = holding)
//
// state        | meaning
// MAIN_GREEN   | main green, side red; holds at 0 until a request is pending
// MAIN_YELLOW  | main yellow, side red
// ALLRED_A     | clearance before side green (also illegal-state recovery)
// SIDE_GREEN   | side green, main red; entry clears req_pending
// SIDE_YELLOW  | side yellow, main red
// ALLRED_B     | clearance before main green
module traffic_phase_sequencer
  import traffic_phase_sequencer_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int T_MAIN_MIN = 10,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int T_SIDE     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oneHz_enable,
  input  logic             side_req,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             req_pending,
  output logic [CNT_W-1:0] seconds_left
);

  if (!duration_ok(T_MAIN_MIN, CNT_W) || !duration_ok(T_YELLOW, CNT_W) ||
      !duration_ok(T_ALLRED, CNT_W) || !duration_ok(T_SIDE, CNT_W)) begin : g_bad_durations
    $error("traffic_phase_sequencer: durations must be >=1 and fit CNT_W");
  end

  phase_t           state, next_state;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             last;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (T_MAIN_MIN)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (oneHz_enable),
    .count    (seconds_left),
    .last     (last)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = CNT_W'(T_MAIN_MIN);
    case (state)
      MAIN_GREEN: if (last && req_pending) begin
        next_state = MAIN_YELLOW;
        load       = 1'b1;
        load_val   = CNT_W'(T_YELLOW);
      end
      MAIN_YELLOW: if (last) begin
        next_state = ALLRED_A;
        load       = 1'b1;
        load_val   = CNT_W'(T_ALLRED);
      end
      ALLRED_A: if (last) begin
        next_state = SIDE_GREEN;
        load       = 1'b1;
        load_val   = CNT_W'(T_SIDE);
      end
      SIDE_GREEN: if (last) begin
        next_state = SIDE_YELLOW;
        load       = 1'b1;
        load_val   = CNT_W'(T_YELLOW);
      end
      SIDE_YELLOW: if (last) begin
        next_state = ALLRED_B;
        load       = 1'b1;
        load_val   = CNT_W'(T_ALLRED);
      end
      ALLRED_B: if (last) begin
        next_state = MAIN_GREEN;
        load       = 1'b1;
        load_val   = CNT_W'(T_MAIN_MIN);
      end
      default: begin
        next_state = ALLRED_A;
        load       = 1'b1;
        load_val   = CNT_W'(T_ALLRED);
      end
    endcase
  end

  // Lights are decoded from next_state so they change in the same clk as
  // the state register, with no combinational path to the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MAIN_GREEN;
      main_light  <= LIGHT_GRN;
      side_light  <= LIGHT_RED;
      req_pending <= 1'b0;
    end else begin
      state      <= next_state;
      main_light <= main_light_of(next_state);
      side_light <= side_light_of(next_state);
      // Entering side green serves the request; a simultaneous sensor hit is absorbed.
      if ((next_state == SIDE_GREEN) && (state != SIDE_GREEN)) begin
        req_pending <= 1'b0;
      end else if (side_req) begin
        req_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
module tb_traffic_phase_sequencer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             oneHz_enable;
  logic             side_req;
  logic [2:0]       main_light;
  logic [2:0]       side_light;
  logic             req_pending;
  logic [CNT_W-1:0] seconds_left;

  int n_vec;
  int n_err;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  traffic_phase_sequencer #(
    .CNT_W      (CNT_W),
    .T_MAIN_MIN (4),
    .T_YELLOW   (2),
    .T_ALLRED   (1),
    .T_SIDE     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .oneHz_enable (oneHz_enable),
    .side_req     (side_req),
    .main_light   (main_light),
    .side_light   (side_light),
    .req_pending  (req_pending),
    .seconds_left (seconds_left)
  );

  always #5 clk = ~clk;

  // Safety invariant, checked on every clk for the whole run.
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (main_light !== R && side_light !== R) begin
        n_err++;
        $display("FAIL invariant: main=%b side=%b, required at least one 100", main_light, side_light);
      end
    end
  end

  // One tick pulse followed by 4 idle clks; side_req optionally held during the tick clk.
  task automatic do_tick(input logic req);
    side_req     = req;
    oneHz_enable = 1'b1;
    @(posedge clk); #1;
    side_req     = 1'b0;
    oneHz_enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    side_req = 1'b1;
    @(posedge clk); #1;
    side_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {G, R, 8'd4, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got m=%b s=%b secs=%0d req=%b, need m=001 s=100 secs=4 req=0",
               main_light, side_light, seconds_left, req_pending);
    end
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {G, R, 8'd4, 1'b0}) begin
      n_err++;
      $display("FAIL reset_static: got m=%b s=%b secs=%0d req=%b, need m=001 s=100 secs=4 req=0",
               main_light, side_light, seconds_left, req_pending);
    end
  endtask

  task automatic test_no_request();
    for (int k = 1; k <= 10; k++) begin
      logic [7:0] exp_s;
      exp_s = (k >= 4) ? 8'd0 : 8'(4 - k);
      do_tick(1'b0);
      n_vec++;
      if ({main_light, side_light, seconds_left, req_pending} !== {G, R, exp_s, 1'b0}) begin
        n_err++;
        $display("FAIL no_request tick %0d: got m=%b s=%b secs=%0d req=%b, need m=001 s=100 secs=%0d req=0",
                 k, main_light, side_light, seconds_left, req_pending, exp_s);
      end
    end
  endtask

  task automatic test_full_cycle();
    logic [2:0] em [13];
    logic [2:0] es [13];
    logic [7:0] et [13];
    logic       er [13];
    em = '{G, G, G, Y, Y, R, R, R, R, R, R, R, G};
    es = '{R, R, R, R, R, R, G, G, G, Y, Y, R, R};
    et = '{8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd4};
    er = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // fresh main green, request latched before tick 1
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_req();
    n_vec++;
    if (req_pending !== 1'b1) begin
      n_err++;
      $display("FAIL full_cycle latch: req=%b need 1", req_pending);
    end
    for (int k = 0; k < 13; k++) begin
      do_tick(1'b0);
      n_vec++;
      if ({main_light, side_light, seconds_left, req_pending} !== {em[k], es[k], et[k], er[k]}) begin
        n_err++;
        $display("FAIL full_cycle tick %0d: got m=%b s=%b secs=%0d req=%b, need m=%b s=%b secs=%0d req=%b",
                 k + 1, main_light, side_light, seconds_left, req_pending, em[k], es[k], et[k], er[k]);
      end
    end
  endtask

  task automatic test_late_request();
    repeat (5) do_tick(1'b0);
    pulse_req();
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {G, R, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL late_hold: got m=%b s=%b secs=%0d req=%b, need m=001 s=100 secs=0 req=1",
               main_light, side_light, seconds_left, req_pending);
    end
    do_tick(1'b0);
    n_vec++;
    if ({main_light, side_light, seconds_left} !== {Y, R, 8'd2}) begin
      n_err++;
      $display("FAIL late_yellow: got m=%b s=%b secs=%0d, need m=010 s=100 secs=2",
               main_light, side_light, seconds_left);
    end
    repeat (9) do_tick(1'b0);
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {G, R, 8'd4, 1'b0}) begin
      n_err++;
      $display("FAIL late_return: got m=%b s=%b secs=%0d req=%b, need m=001 s=100 secs=4 req=0",
               main_light, side_light, seconds_left, req_pending);
    end
  endtask

  task automatic test_back_to_back();
    pulse_req();
    repeat (6) do_tick(1'b0);
    // tick entering SIDE_GREEN with the sensor active: clear wins
    do_tick(1'b1);
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {R, G, 8'd3, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_entry: got m=%b s=%b secs=%0d req=%b, need m=100 s=001 secs=3 req=0",
               main_light, side_light, seconds_left, req_pending);
    end
    repeat (3) do_tick(1'b0);
    pulse_req();
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {R, Y, 8'd2, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_relatch: got m=%b s=%b secs=%0d req=%b, need m=100 s=010 secs=2 req=1",
               main_light, side_light, seconds_left, req_pending);
    end
    repeat (3) do_tick(1'b0);
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {G, R, 8'd4, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_main: got m=%b s=%b secs=%0d req=%b, need m=001 s=100 secs=4 req=1",
               main_light, side_light, seconds_left, req_pending);
    end
    repeat (3) do_tick(1'b0);
    n_vec++;
    if ({main_light, seconds_left} !== {G, 8'd1}) begin
      n_err++;
      $display("FAIL b2b_min_green: got m=%b secs=%0d, need m=001 secs=1", main_light, seconds_left);
    end
    do_tick(1'b0);
    n_vec++;
    if ({main_light, side_light, seconds_left} !== {Y, R, 8'd2}) begin
      n_err++;
      $display("FAIL b2b_second_yellow: got m=%b s=%b secs=%0d, need m=010 s=100 secs=2",
               main_light, side_light, seconds_left);
    end
    repeat (3) do_tick(1'b0);
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {R, G, 8'd3, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_second_side: got m=%b s=%b secs=%0d req=%b, need m=100 s=001 secs=3 req=0",
               main_light, side_light, seconds_left, req_pending);
    end
  endtask

  task automatic test_mid_reset();
    do_tick(1'b0);
    n_vec++;
    if ({side_light, seconds_left} !== {G, 8'd2}) begin
      n_err++;
      $display("FAIL mid_pre: got s=%b secs=%0d, need s=001 secs=2", side_light, seconds_left);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({main_light, side_light, seconds_left, req_pending} !== {G, R, 8'd4, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: got m=%b s=%b secs=%0d req=%b, need m=001 s=100 secs=4 req=0",
               main_light, side_light, seconds_left, req_pending);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    oneHz_enable = 1'b0;
    side_req     = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_no_request();
    test_full_cycle();
    test_late_request();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
